// File: rtl/param_decoder.sv
// Registered SEL_W-to-2**SEL_W decoder: one-hot, thermometer or timed walking-one scan,
// with valid/ready handshakes on the request and code sides.
module param_decoder #(
    parameter int SEL_W     = 3,
    parameter int DWELL_W   = 8,
    parameter bit ZERO_IDLE = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [SEL_W-1:0]               in_sel,
    input  logic [1:0]                     in_mode,
    input  logic [DWELL_W-1:0]             in_dwell,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [(32'sd1 << SEL_W)-32'sd1:0] out_code,
    output logic                           busy
);

    localparam int OUT_W = 32'sd1 << SEL_W;

    localparam logic [1:0] MODE_THERM = 2'b01;
    localparam logic [1:0] MODE_SCAN  = 2'b10;

    localparam logic [SEL_W-1:0]   SEL_ONE = {{(SEL_W-1){1'b0}}, 1'b1};
    localparam logic [DWELL_W-1:0] CNT_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SCAN = 2'b01,
        ST_WAIT = 2'b10
    } state_t;

    // Single-position code f(k); with ZERO_IDLE, select 0 means "nothing lit".
    function automatic logic [OUT_W-1:0] map_onehot(input logic [SEL_W-1:0] k);
        logic [OUT_W-1:0] code;
        code = '0;
        for (int i = 32'sd0; i < OUT_W; i++) begin
            if (ZERO_IDLE) begin
                code[i] = (int'(k) == i + 32'sd1);
            end else begin
                code[i] = (int'(k) == i);
            end
        end
        return code;
    endfunction

    // Union of f(0..k).
    function automatic logic [OUT_W-1:0] map_therm(input logic [SEL_W-1:0] k);
        logic [OUT_W-1:0] code;
        code = '0;
        for (int i = 32'sd0; i < OUT_W; i++) begin
            if (ZERO_IDLE) begin
                code[i] = (i < int'(k));
            end else begin
                code[i] = (i <= int'(k));
            end
        end
        return code;
    endfunction

    state_t               state_r, state_s;
    logic                 out_valid_r, out_valid_s;
    logic [OUT_W-1:0]     out_code_r, out_code_s;
    logic [SEL_W-1:0]     idx_r, idx_s;
    logic [SEL_W-1:0]     sel_r, sel_s;
    logic [DWELL_W-1:0]   cnt_r, cnt_s;
    logic [DWELL_W-1:0]   dwell_r, dwell_s;

    logic                 accept_s;
    logic                 out_fire_s;
    logic                 last_beat_s;
    logic                 dwell_zero_s;
    logic                 wait_done_s;
    logic [SEL_W-1:0]     idx_inc_s;

    assign in_ready     = !rst && (state_r == ST_IDLE) && (!out_valid_r || out_ready);
    assign accept_s     = in_valid && in_ready;
    assign out_fire_s   = out_valid_r && out_ready;
    assign last_beat_s  = (idx_r == sel_r);
    assign dwell_zero_s = (dwell_r == '0);
    // A zero count in WAIT is unreachable; treating it as done keeps the FSM from stalling.
    assign wait_done_s  = (cnt_r <= CNT_ONE);
    assign idx_inc_s    = idx_r + SEL_ONE;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && (in_mode == MODE_SCAN)) begin
                    state_s = ST_SCAN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (!out_fire_s) begin
                    state_s = ST_SCAN;
                end else if (last_beat_s) begin
                    state_s = ST_IDLE;
                end else if (dwell_zero_s) begin
                    state_s = ST_SCAN;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_done_s) begin
                    state_s = ST_SCAN;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output logic: next values of the registered code, valid, beat index and dwell counter.
    always_comb begin
        out_valid_s = out_valid_r;
        out_code_s  = out_code_r;
        idx_s       = idx_r;
        sel_s       = sel_r;
        cnt_s       = cnt_r;
        dwell_s     = dwell_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    out_valid_s = 1'b1;
                    case (in_mode)
                        MODE_THERM: begin
                            out_code_s = map_therm(in_sel);
                        end
                        MODE_SCAN: begin
                            out_code_s = map_onehot({SEL_W{1'b0}});
                            idx_s      = '0;
                            sel_s      = in_sel;
                            dwell_s    = in_dwell;
                            cnt_s      = '0;
                        end
                        default: begin
                            out_code_s = map_onehot(in_sel);
                        end
                    endcase
                end else if (out_fire_s) begin
                    out_valid_s = 1'b0;
                end else begin
                    out_valid_s = out_valid_r;
                end
            end
            ST_SCAN: begin
                if (!out_fire_s) begin
                    out_valid_s = 1'b1;
                end else if (last_beat_s) begin
                    out_valid_s = 1'b0;
                end else if (dwell_zero_s) begin
                    idx_s      = idx_inc_s;
                    out_code_s = map_onehot(idx_inc_s);
                end else begin
                    out_valid_s = 1'b0;
                    cnt_s       = dwell_r;
                end
            end
            ST_WAIT: begin
                if (wait_done_s) begin
                    cnt_s       = '0;
                    idx_s       = idx_inc_s;
                    out_code_s  = map_onehot(idx_inc_s);
                    out_valid_s = 1'b1;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            default: begin
                out_valid_s = 1'b0;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_code_r  <= '0;
            idx_r       <= '0;
            sel_r       <= '0;
            cnt_r       <= '0;
            dwell_r     <= '0;
        end else begin
            out_valid_r <= out_valid_s;
            out_code_r  <= out_code_s;
            idx_r       <= idx_s;
            sel_r       <= sel_s;
            cnt_r       <= cnt_s;
            dwell_r     <= dwell_s;
        end
    end

    assign out_valid = out_valid_r;
    assign out_code  = out_code_r;
    assign busy      = (state_r != ST_IDLE) || out_valid_r;

endmodule

// File: tb/tb_param_decoder.sv
// Bench for param_decoder: two instances (ZERO_IDLE 0 and 1) share directed stimulus and are
// checked every cycle against a beat-schedule model plus hand-written expected codes.
module tb_param_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid;
    logic [2:0] in_sel;
    logic [1:0] in_mode;
    logic [7:0] in_dwell;
    logic       out_ready;

    logic [1:0]      rdy_v;
    logic [1:0]      val_v;
    logic [1:0]      busy_v;
    logic [1:0][7:0] code_v;

    int phase = 0;
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    param_decoder #(.SEL_W(3), .DWELL_W(8), .ZERO_IDLE(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_v[0]),
        .in_sel(in_sel), .in_mode(in_mode), .in_dwell(in_dwell),
        .out_valid(val_v[0]), .out_ready(out_ready), .out_code(code_v[0]), .busy(busy_v[0])
    );

    param_decoder #(.SEL_W(3), .DWELL_W(8), .ZERO_IDLE(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_v[1]),
        .in_sel(in_sel), .in_mode(in_mode), .in_dwell(in_dwell),
        .out_valid(val_v[1]), .out_ready(out_ready), .out_code(code_v[1]), .busy(busy_v[1])
    );

    // f(k) for instance z (z = ZERO_IDLE value).
    function automatic logic [7:0] f_map(input int z, input int k);
        logic [7:0] one;
        one = 8'h01;
        if (z == 1) return (k == 0) ? 8'h00 : (one << (k - 1));
        return one << k;
    endfunction

    // Hand-computed codes per phase, instance and beat number.
    function automatic logic [7:0] lit(input int ph, input int z, input int n);
        logic [7:0] t [8];
        t = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        case (ph * 2 + z)
            2:  t = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
            3:  t = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};
            4:  t[0] = 8'h3F;
            5:  t[0] = 8'h1F;
            6:  t = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00};
            7:  t = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
            8:  t[0] = 8'h40;
            9:  t[0] = 8'h20;
            10: begin t[0] = 8'h01; t[1] = 8'h02; end
            11: begin t[0] = 8'h00; t[1] = 8'h01; end
            12: begin t[0] = 8'h04; t[1] = 8'h01; end
            13: begin t[0] = 8'h02; t[1] = 8'h00; end
            14: begin t[0] = 8'h01; t[1] = 8'h02; end
            15: begin t[0] = 8'h00; t[1] = 8'h01; end
            default: ;
        endcase
        return t[n];
    endfunction

    function automatic int beats_in_phase(input int ph);
        case (ph)
            1: return 8;
            2: return 1;
            3: return 4;
            4: return 1;
            5: return 2;
            6: return 2;
            7: return 2;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string name, input int z, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", name, z, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Stimulus.
    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sel = 3'd0; in_mode = 2'b00; in_dwell = 8'd0; out_ready = 1'b1;
        step(3);
        rst = 1'b0;
        step(2);
        phase = 1;
        for (int n = 0; n < 8; n++) begin
            in_valid = 1'b1; in_mode = 2'b00; in_sel = 3'(n);
            step(1);
        end
        in_valid = 1'b0;
        step(3);
        phase = 2;
        in_valid = 1'b1; in_mode = 2'b01; in_sel = 3'd5;
        step(1);
        in_valid = 1'b0;
        step(4);
        phase = 3;
        in_valid = 1'b1; in_mode = 2'b10; in_sel = 3'd3; in_dwell = 8'd2;
        step(1);
        in_valid = 1'b0;
        step(16);
        phase = 4;
        out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'b00; in_sel = 3'd6;
        step(1);
        in_valid = 1'b0;
        step(4);
        out_ready = 1'b1;
        step(3);
        phase = 5;
        in_valid = 1'b1; in_mode = 2'b10; in_sel = 3'd7; in_dwell = 8'd0;
        step(1);
        in_valid = 1'b0;
        step(2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(10);
        phase = 6;
        in_valid = 1'b1; in_mode = 2'b11; in_sel = 3'd2;
        step(1);
        in_valid = 1'b0;
        step(3);
        in_valid = 1'b1; in_mode = 2'b10; in_sel = 3'd0; in_dwell = 8'd5;
        step(1);
        in_valid = 1'b0;
        step(4);
        phase = 7;
        in_valid = 1'b1; in_mode = 2'b10; in_sel = 3'd1; in_dwell = 8'd255;
        step(1);
        in_valid = 1'b0;
        step(270);
        phase = 99;
    end

    // Compare process: model of pending beats and when each becomes visible.
    initial begin
        logic [7:0] mq [2][16];
        int  mlen [2];
        bit  mscan [2];
        int  mshow [2];
        int  mdwell [2];
        int  hs_n [2];
        int  hs_cyc [2][16];
        int  acc_cyc [2];
        int  bp_n [2];
        bit  rdy_due [2];
        int  prev_phase;
        bit  rst_prev;
        bit  ev, er, eb;
        logic [7:0] c;
        prev_phase = 0;
        rst_prev = 1'b0;
        for (int z = 0; z < 2; z++) begin
            mlen[z] = 0; mscan[z] = 1'b0; mshow[z] = 0; mdwell[z] = 0;
            hs_n[z] = 0; acc_cyc[z] = -1; bp_n[z] = 0; rdy_due[z] = 1'b0;
        end
        forever begin
            @(negedge clk);
            if (phase != prev_phase) begin
                for (int z = 0; z < 2; z++) begin
                    check("beat_count", z, hs_n[z], beats_in_phase(prev_phase));
                    if (prev_phase == 1)
                        for (int n = 1; n < hs_n[z] && n < 8; n++)
                            check("sweep_spacing", z, hs_cyc[z][n] - hs_cyc[z][n-1], 1);
                    if ((prev_phase == 2 || prev_phase == 3) && hs_n[z] > 0)
                        check("first_beat_latency", z, hs_cyc[z][0] - acc_cyc[z], 1);
                    if (prev_phase == 3)
                        for (int n = 1; n < hs_n[z] && n < 4; n++)
                            check("scan_spacing_dwell2", z, hs_cyc[z][n] - hs_cyc[z][n-1], 3);
                    if (prev_phase == 4)
                        check("bp_hold_cycles", z, bp_n[z], 4);
                    if (prev_phase == 7 && hs_n[z] >= 2)
                        check("scan_spacing_dwell255", z, hs_cyc[z][1] - hs_cyc[z][0], 256);
                    hs_n[z] = 0; acc_cyc[z] = -1; bp_n[z] = 0; rdy_due[z] = 1'b0;
                end
                prev_phase = phase;
            end
            if (phase == 99 || cyc > 3000) begin
                if (phase != 99) check("timeout", 0, 32'(phase), 32'd99);
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
            for (int z = 0; z < 2; z++) begin
                ev = (mlen[z] > 0) && (cyc >= mshow[z]);
                er = !rst && (mlen[z] == 0 || (!mscan[z] && ev && out_ready));
                eb = (mlen[z] > 0);
                if (cyc >= 1) begin
                    check("out_valid", z, val_v[z], ev);
                    check("in_ready", z, rdy_v[z], er);
                    check("busy", z, busy_v[z], eb);
                    if (ev) check("out_code", z, code_v[z], mq[z][0]);
                end
                if (cyc == 1) begin
                    check("reset_out_valid", z, val_v[z], 1'b0);
                    check("reset_out_code", z, code_v[z], 8'h00);
                    check("reset_busy", z, busy_v[z], 1'b0);
                    check("reset_in_ready", z, rdy_v[z], 1'b0);
                end
                if (rst_prev && !rst) begin
                    check("post_reset_out_valid", z, val_v[z], 1'b0);
                    check("post_reset_out_code", z, code_v[z], 8'h00);
                    check("post_reset_busy", z, busy_v[z], 1'b0);
                    check("post_reset_in_ready", z, rdy_v[z], 1'b1);
                end
                if (rdy_due[z]) begin
                    check("ready_after_scan", z, rdy_v[z], 1'b1);
                    rdy_due[z] = 1'b0;
                end
                if (phase == 4 && !out_ready && val_v[z]) begin
                    bp_n[z]++;
                    check("bp_code", z, code_v[z], lit(4, z, 0));
                    check("bp_in_ready", z, rdy_v[z], 1'b0);
                end
                if (!rst && in_valid && rdy_v[z] && acc_cyc[z] < 0) acc_cyc[z] = cyc;
                if (!rst && val_v[z] && out_ready) begin
                    if (hs_n[z] < 16) hs_cyc[z][hs_n[z]] = cyc;
                    if (phase >= 1 && phase <= 7 && hs_n[z] < 8)
                        check("beat_code", z, code_v[z], lit(phase, z, hs_n[z]));
                    hs_n[z]++;
                    if (phase == 3 && hs_n[z] == 4) rdy_due[z] = 1'b1;
                end
                // Advance the model across the coming clock edge.
                if (rst) begin
                    mlen[z] = 0;
                    mscan[z] = 1'b0;
                end else begin
                    if (ev && out_ready) begin
                        for (int j = 0; j < 15; j++) mq[z][j] = mq[z][j+1];
                        mlen[z]--;
                        if (mlen[z] > 0) mshow[z] = cyc + 1 + mdwell[z];
                        else mscan[z] = 1'b0;
                    end
                    if (in_valid && er) begin
                        mshow[z] = cyc + 1;
                        mdwell[z] = int'(in_dwell);
                        case (in_mode)
                            2'b01: begin
                                c = 8'h00;
                                for (int j = 0; j <= int'(in_sel); j++) c = c | f_map(z, j);
                                mq[z][mlen[z]] = c;
                                mlen[z]++;
                            end
                            2'b10: begin
                                mscan[z] = 1'b1;
                                for (int j = 0; j <= int'(in_sel); j++) begin
                                    mq[z][mlen[z]] = f_map(z, j);
                                    mlen[z]++;
                                end
                            end
                            default: begin
                                mq[z][mlen[z]] = f_map(z, int'(in_sel));
                                mlen[z]++;
                            end
                        endcase
                    end
                end
            end
            rst_prev = rst;
            cyc++;
        end
    end

endmodule
